// File: rtl/registro_pkg.sv
// Shared definitions for the registro family (parallel register, PISO transmitter,
// future SIPO receiver): operation codes and the IDLE/SHIFT state type.
package registro_pkg;

    localparam logic [1:0] OPR_RUN  = 2'd0;
    localparam logic [1:0] OPR_HOLD = 2'd1;
    localparam logic [1:0] OPR_CLR  = 2'd2;  // 2'd3 aliases CLEAR

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    // Both 2'd2 and 2'd3 act as a synchronous clear.
    function automatic logic opr_is_clr(input logic [1:0] opr);
        return opr[1];
    endfunction

endpackage

// File: rtl/contador_bits.sv
// Bit counter with synchronous clear, count enable and terminal-count flag.
module contador_bits #(
    parameter int unsigned W  = 3,
    parameter logic [W-1:0] TC = '1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [W-1:0] cnt_q;

    // Clear has priority over enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    // Terminal count reached.
    always_comb begin
        tc = (cnt_q == TC);
    end

endmodule

// File: rtl/registro_ps_tx.sv
// Parallel-in/serial-out transmitter with valid/ready load and back-to-back words.
// Optional macro REGISTRO_PS_PARITY_EN appends an even-parity bit to each word.
module registro_ps_tx
    import registro_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   opr,
    input  logic [N-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic         sout,
    output logic         sout_valid,
    output logic         busy,
    output logic         done
);

`ifdef REGISTRO_PS_PARITY_EN
    localparam int unsigned LAST = N;
`else
    localparam int unsigned LAST = N - 1;
`endif
    localparam int unsigned CW       = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(LAST);

    state_t       state_q, state_d;
    logic [N-1:0] shreg_q, shreg_d;
    logic [N-1:0] shreg_shifted;
    logic         done_q, done_d;
    logic         cnt_clr, cnt_en, cnt_tc;
    logic         run, clr_op, last, load, data_bit;
`ifdef REGISTRO_PS_PARITY_EN
    logic         parity_q, parity_d;
`endif

    contador_bits #(
        .W  (CW),
        .TC (LAST_CNT)
    ) u_contador (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (cnt_tc)
    );

    // Output decode and handshake; din_ready is forced low while reset is held.
    always_comb begin
        run        = (opr == OPR_RUN);
        clr_op     = opr_is_clr(opr);
        last       = (state_q == SHIFT) && cnt_tc && run;
        din_ready  = rst && (((state_q == IDLE) && run) || last);
        load       = din_valid && din_ready;
        busy       = (state_q == SHIFT);
        sout_valid = (state_q == SHIFT) && run;
        done       = done_q;
        if (MSB_FIRST) begin
            data_bit      = shreg_q[N-1];
            shreg_shifted = {shreg_q[N-2:0], 1'b0};
        end else begin
            data_bit      = shreg_q[0];
            shreg_shifted = {1'b0, shreg_q[N-1:1]};
        end
`ifdef REGISTRO_PS_PARITY_EN
        // Terminal count marks the parity slot after the N data bits.
        sout = cnt_tc ? parity_q : data_bit;
`else
        sout = data_bit;
`endif
    end

    // Next-state: clear beats load, load beats shifting.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        done_d  = last;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
`ifdef REGISTRO_PS_PARITY_EN
        parity_d = parity_q;
`endif
        if (clr_op) begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_clr = 1'b1;
        end else if (load) begin
            state_d = SHIFT;
            shreg_d = din;
            cnt_clr = 1'b1;
`ifdef REGISTRO_PS_PARITY_EN
            parity_d = ^din;
`endif
        end else if ((state_q == SHIFT) && run) begin
            shreg_d = shreg_shifted;
            if (cnt_tc) begin
                state_d = IDLE;
                cnt_clr = 1'b1;
            end else begin
                cnt_en = 1'b1;
            end
        end
    end

    // State, shift register and done pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            done_q  <= done_d;
        end
    end

`ifdef REGISTRO_PS_PARITY_EN
    // Parity of the loaded word, captured at load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

endmodule

// File: tb/tb_registro_ps_tx.sv
// Self-checking bench for registro_ps_tx: directed scenarios plus random traffic,
// compared against a queue-of-bits reference model.
module tb_registro_ps_tx;

    localparam int unsigned N = 4;
`ifdef REGISTRO_PS_PARITY_EN
    localparam bit MSB = 1'b0;
`else
    localparam bit MSB = 1'b1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [1:0]   opr = 2'd0;
    logic [N-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         din_ready, sout, sout_valid, busy, done;

    int checks = 0;
    int errors = 0;

    // Reference: bits still to be sent for the word in flight, plus expected done.
    logic q[$];
    logic done_exp = 1'b0;

    registro_ps_tx #(
        .N         (N),
        .MSB_FIRST (MSB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .opr        (opr),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0b exp=%0b", tag, got, exp);
        end
    endtask

    function automatic logic exp_ready();
        return rst && (opr == 2'd0) && (q.size() <= 1);
    endfunction

    task automatic check_outputs();
        chk("busy", busy, rst && (q.size() > 0));
        chk("sout_valid", sout_valid, rst && (q.size() > 0) && (opr == 2'd0));
        chk("sout", sout, (q.size() > 0) ? q[0] : 1'b0);
        chk("din_ready", din_ready, exp_ready());
        chk("done", done, done_exp);
    endtask

    task automatic model_reset();
        q.delete();
        done_exp = 1'b0;
    endtask

    // Applies one clock edge to the reference using the inputs present at that edge.
    task automatic model_edge();
        logic rdy;
        logic dn;
        if (!rst) begin
            model_reset();
            return;
        end
        rdy = exp_ready();
        dn  = 1'b0;
        if (opr[1]) begin
            q.delete();
        end else if (opr == 2'd0) begin
            if (q.size() == 1) dn = 1'b1;
            if (q.size() > 0) void'(q.pop_front());
            if (din_valid && rdy) begin
                for (int i = 0; i < N; i++) q.push_back(MSB ? din[N-1-i] : din[i]);
`ifdef REGISTRO_PS_PARITY_EN
                q.push_back(^din);
`endif
            end
        end
        done_exp = dn;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_outputs();
            @(posedge clk);
            model_edge();
            #1;
        end
    endtask

    task automatic drive(input logic [1:0] o, input logic v, input logic [N-1:0] d);
        opr       = o;
        din_valid = v;
        din       = d;
    endtask

    initial begin
        // Reset held: everything low even with opr=RUN.
        drive(2'd0, 1'b1, 4'hF);
        cyc(2);
        rst = 1'b1;
        drive(2'd0, 1'b0, 4'h0);
        cyc(1);

        // Single word 1011.
        drive(2'd0, 1'b1, 4'b1011);
        cyc(1);
        drive(2'd0, 1'b0, 4'h0);
        cyc(7);

        // Back-to-back A then 5 with din_valid held.
        drive(2'd0, 1'b1, 4'hA);
        cyc(1);
        drive(2'd0, 1'b1, 4'h5);
        cyc(4);
        drive(2'd0, 1'b0, 4'h0);
        cyc(7);

        // Hold for 3 cycles mid-word.
        drive(2'd0, 1'b1, 4'b1011);
        cyc(1);
        drive(2'd0, 1'b0, 4'h0);
        cyc(2);
        drive(2'd1, 1'b0, 4'h0);
        cyc(3);
        drive(2'd0, 1'b0, 4'h0);
        cyc(6);

        // Clear mid-word, load ignored during clear.
        drive(2'd0, 1'b1, 4'b0110);
        cyc(1);
        drive(2'd0, 1'b0, 4'h0);
        cyc(2);
        drive(2'd2, 1'b1, 4'hF);
        cyc(1);
        drive(2'd0, 1'b0, 4'h0);
        cyc(3);

        // Asynchronous reset mid-word.
        drive(2'd0, 1'b1, 4'b1101);
        cyc(1);
        drive(2'd0, 1'b0, 4'h0);
        cyc(2);
        rst = 1'b0;
        model_reset();
        #1;
        check_outputs();
        cyc(2);
        rst = 1'b1;
        cyc(2);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            int unsigned r;
            logic [1:0] o;
            r = $urandom_range(0, 99);
            if (r < 70)      o = 2'd0;
            else if (r < 88) o = 2'd1;
            else             o = (r < 94) ? 2'd2 : 2'd3;
            drive(o, 1'($urandom_range(0, 1)), N'($urandom));
            cyc(1);
        end
        drive(2'd0, 1'b0, 4'h0);
        cyc(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
